// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: latches one-cycle byte requests from N_REQ sources and feeds
// them round-robin to a single uart_tx through a start/busy handshake.
module uart_tx_arbiter #(
  parameter int unsigned  N_REQ       = 4,
  parameter int unsigned  DATA_W      = 8,
  parameter int unsigned  ACK_TIMEOUT = 15,
  localparam int unsigned ID_W        = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_pulse,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic                    tx_busy,
  output logic                    tx_start,
  output logic [DATA_W-1:0]       tx_data,
  output logic [ID_W-1:0]         grant_id,
  output logic [N_REQ-1:0]        pending,
  output logic [N_REQ-1:0]        drop,
  output logic                    tx_err
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ID_W-1:0]   ptr_q;
  logic [ID_W-1:0]   ptr_next;
  logic [DATA_W-1:0] latched_q [N_REQ];
  logic [ID_W-1:0]   win;
  logic              win_valid;
  int unsigned       scan_idx;
  logic              grant;
  logic [N_REQ-1:0]  grant_clr;
  logic              tx_start_d;
  logic              tx_err_d;

  // Round-robin winner: first pending index scanning ptr, ptr+1, ... mod N_REQ
  always_comb begin
    win       = '0;
    win_valid = 1'b0;
    scan_idx  = 0;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      scan_idx = 32'(ptr_q) + off;
      if (scan_idx >= N_REQ) scan_idx = scan_idx - N_REQ;
      if (!win_valid && pending[ID_W'(scan_idx)]) begin
        win_valid = 1'b1;
        win       = ID_W'(scan_idx);
      end
    end
  end

  assign ptr_next  = (32'(win) == N_REQ - 1) ? '0 : win + ID_W'(1);
  assign grant_clr = grant ? (N_REQ'(1) << win) : '0;

  // Next-state and registered-output decode
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    grant      = 1'b0;
    tx_start_d = 1'b0;
    tx_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_valid) begin
          grant   = 1'b1;
          state_d = START;
        end
      end
      START: begin
        tx_start_d = 1'b1;
        cnt_d      = '0;
        state_d    = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (({1'b0, cnt_q} + 9'd1) >= 9'(ACK_TIMEOUT)) begin
          // Transmitter never acknowledged: report and give the byte up
          tx_err_d = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state, pointer and transmitter-side outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ptr_q    <= '0;
      tx_start <= 1'b0;
      tx_err   <= 1'b0;
      tx_data  <= '0;
      grant_id <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tx_start <= tx_start_d;
      tx_err   <= tx_err_d;
      if (grant) begin
        grant_id <= win;
        tx_data  <= latched_q[win];
        ptr_q    <= ptr_next;
      end
    end
  end

  // Request capture; a pulse coinciding with its own grant is accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      drop    <= '0;
      for (int unsigned i = 0; i < N_REQ; i++) latched_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        drop[i] <= req_pulse[i] & pending[i] & ~grant_clr[i];
        if (req_pulse[i] && (!pending[i] || grant_clr[i])) begin
          pending[i]   <= 1'b1;
          latched_q[i] <= req_data[i*DATA_W +: DATA_W];
        end else if (grant_clr[i]) begin
          pending[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level arbitration model.
module tb_uart_tx_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_pulse;
  logic [N*DW-1:0] req_data;
  logic          tx_busy;
  logic          tx_start;
  logic [DW-1:0] tx_data;
  logic [1:0]    grant_id;
  logic [N-1:0]  pending;
  logic [N-1:0]  drop;
  logic          tx_err;

  int errors = 0;
  int checks = 0;

  // transmitter responder state
  bit          resp_en    = 1'b1;
  int          resp_delay = 2;
  int          resp_len   = 5;
  int          wait_ctr   = 0;
  int          busy_left  = 0;
  bit          busy_s     = 1'b0;

  uart_tx_arbiter #(.N_REQ(N), .DATA_W(DW), .ACK_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .req_pulse(req_pulse), .req_data(req_data),
    .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
    .grant_id(grant_id), .pending(pending), .drop(drop), .tx_err(tx_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // One clock; sample after the edge, then advance the modelled uart_tx
  task automatic tick();
    @(posedge clk);
    #1;
    busy_s = tx_busy;
    if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) tx_busy = 1'b0;
    end
    if (tx_start && resp_en) wait_ctr = resp_delay;
    if (wait_ctr > 0) begin
      wait_ctr--;
      if (wait_ctr == 0) begin
        tx_busy   = 1'b1;
        busy_left = resp_len;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; req_pulse = '0; tx_busy = 1'b0; wait_ctr = 0; busy_left = 0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic wait_start(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (tx_start) begin seen = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_pulse = 4'hF; req_data = 32'hDEADBEEF; tx_busy = 1'b0;
    tick(); tick();
    rst = 1'b0; req_pulse = '0;
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start: got %b want 0", tx_start); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant_id: got %0d want 0", grant_id); end
    checks++; if (pending !== 4'h0) begin errors++; $display("FAIL reset_pending: got %b want 0000", pending); end
    checks++; if (drop !== 4'h0) begin errors++; $display("FAIL reset_drop: got %b want 0000", drop); end
    checks++; if (tx_err !== 1'b0) begin errors++; $display("FAIL reset_tx_err: got %b want 0", tx_err); end
  endtask

  task automatic test_single();
    int extra;
    bit seen;
    do_reset();
    resp_en = 1'b1; resp_delay = 2; resp_len = 20;
    req_data = 32'($urandom); req_data[15:8] = 8'h41; req_pulse = 4'b0010;
    tick();
    req_pulse = '0;
    checks++; if (pending !== 4'b0010) begin errors++; $display("FAIL single_pending_t1: got %b want 0010", pending); end
    tick();
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL single_start_early: got %b want 0", tx_start); end
    checks++; if (grant_id !== 2'd1) begin errors++; $display("FAIL single_grant_id: got %0d want 1", grant_id); end
    checks++; if (tx_data !== 8'h41) begin errors++; $display("FAIL single_tx_data: got %h want 41", tx_data); end
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL single_pending_clr: got %b want 0000", pending); end
    tick();
    checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL single_start_t3: got %b want 1", tx_start); end
    tick();
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL single_start_width: got %b want 0", tx_start); end
    extra = 0;
    for (int i = 0; i < 40; i++) begin tick(); if (tx_start) extra++; end
    checks++; if (extra != 0) begin errors++; $display("FAIL single_extra_starts: got %0d want 0", extra); end
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL single_pending_end: got %b want 0000", pending); end
    // after granting 1 the pointer sits at 2, so 2 beats 1
    resp_len = 3;
    req_data = 32'h00_22_11_00; req_pulse = 4'b0110;
    tick();
    req_pulse = '0;
    wait_start(20, seen);
    checks++; if (!seen || grant_id !== 2'd2) begin errors++; $display("FAIL single_ptr_next: seen=%b grant %0d want 2", seen, grant_id); end
  endtask

  task automatic test_simultaneous();
    int ids [4];
    int dat [4];
    int n;
    int bad;
    do_reset();
    resp_en = 1'b1; resp_delay = 2; resp_len = 5;
    for (int i = 0; i < 4; i++) begin ids[i] = -1; dat[i] = -1; end
    n = 0; bad = 0;
    req_data = 32'h13121110; req_pulse = 4'b1111;
    tick();
    req_pulse = '0;
    for (int c = 0; c < 200; c++) begin
      tick();
      if (tx_start) begin
        if (busy_s) bad++;
        if (n < 4) begin ids[n] = int'(grant_id); dat[n] = int'(tx_data); end
        n++;
      end
    end
    checks++; if (n != 4) begin errors++; $display("FAIL simul_start_count: got %0d want 4", n); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ids[i] != i || dat[i] != 'h10 + i) begin
        errors++; $display("FAIL simul_order_%0d: got id %0d data %0h want id %0d data %0h", i, ids[i], dat[i], i, 'h10 + i);
      end
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL simul_start_while_busy: got %0d want 0", bad); end
  endtask

  task automatic test_fairness();
    int ids [6];
    int n;
    logic [N-1:0] repulse;
    do_reset();
    resp_en = 1'b1; resp_delay = 1; resp_len = 3;
    for (int i = 0; i < 6; i++) ids[i] = -1;
    n = 0; repulse = '0;
    req_data = 32'h000C000A; req_pulse = 4'b0101;
    tick();
    req_pulse = '0;
    for (int c = 0; c < 300 && n < 6; c++) begin
      req_pulse = repulse;
      tick();
      req_pulse = '0; repulse = '0;
      if (tx_start) begin
        ids[n] = int'(grant_id);
        n++;
        repulse = 4'b0001 << grant_id;
      end
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (ids[i] != ((i % 2 == 0) ? 0 : 2)) begin
        errors++; $display("FAIL fair_grant_%0d: got %0d want %0d", i, ids[i], (i % 2 == 0) ? 0 : 2);
      end
    end
  endtask

  task automatic test_overrun();
    bit seen;
    int drops;
    int sent3;
    do_reset();
    resp_en = 1'b1; resp_delay = 2; resp_len = 6;
    req_data = 32'h00000055; req_pulse = 4'b0001;
    tick();
    req_pulse = '0;
    wait_start(10, seen);
    checks++; if (!seen) begin errors++; $display("FAIL ovr_first_start: got none want start"); end
    req_data = 32'hAA000000; req_pulse = 4'b1000;
    tick();
    req_data = 32'hBB000000; req_pulse = 4'b1000;
    tick();
    req_pulse = '0;
    checks++; if (drop !== 4'b1000) begin errors++; $display("FAIL ovr_drop: got %b want 1000", drop); end
    checks++; if (pending[3] !== 1'b1) begin errors++; $display("FAIL ovr_pending3: got %b want 1", pending[3]); end
    tick();
    checks++; if (drop !== 4'b0000) begin errors++; $display("FAIL ovr_drop_width: got %b want 0000", drop); end
    drops = 0; sent3 = -1;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (drop != 0) drops++;
      if (tx_start && grant_id == 2'd3) sent3 = int'(tx_data);
    end
    checks++; if (drops != 0) begin errors++; $display("FAIL ovr_extra_drop: got %0d want 0", drops); end
    checks++; if (sent3 != 'hAA) begin errors++; $display("FAIL ovr_byte: got %0h want aa", sent3); end
    // pulse landing on the grant edge of the same requester is accepted
    req_data = 32'h00210000; req_pulse = 4'b0100;
    tick();
    req_data = 32'h00220000; req_pulse = 4'b0100;
    tick();
    req_pulse = '0;
    checks++; if (drop !== 4'b0000) begin errors++; $display("FAIL setwins_drop: got %b want 0000", drop); end
    checks++; if (pending !== 4'b0100) begin errors++; $display("FAIL setwins_pending: got %b want 0100", pending); end
    checks++; if (tx_data !== 8'h21 || grant_id !== 2'd2) begin errors++; $display("FAIL setwins_first: got %h/%0d want 21/2", tx_data, grant_id); end
    wait_start(10, seen);
    wait_start(60, seen);
    checks++; if (!seen || tx_data !== 8'h22) begin errors++; $display("FAIL setwins_second: seen=%b got %h want 22", seen, tx_data); end
  endtask

  task automatic test_timeout();
    bit seen;
    int k_err;
    int extra;
    do_reset();
    resp_en = 1'b0;
    req_data = 32'h00323100; req_pulse = 4'b0110;
    tick();
    req_pulse = '0;
    wait_start(10, seen);
    checks++; if (!seen || grant_id !== 2'd1) begin errors++; $display("FAIL tmo_first: seen=%b grant %0d want 1", seen, grant_id); end
    k_err = -1; extra = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (tx_start) extra++;
      if (tx_err) begin k_err = i; break; end
    end
    checks++; if (k_err != 15) begin errors++; $display("FAIL tmo_cycles: got %0d want 15", k_err); end
    checks++; if (extra != 0) begin errors++; $display("FAIL tmo_retry: got %0d starts want 0", extra); end
    resp_en = 1'b1; resp_delay = 2; resp_len = 4;
    tick();
    checks++; if (tx_err !== 1'b0) begin errors++; $display("FAIL tmo_err_width: got %b want 0", tx_err); end
    tick();
    checks++; if (tx_start !== 1'b1 || grant_id !== 2'd2 || tx_data !== 8'h32) begin
      errors++; $display("FAIL tmo_next: got start %b id %0d data %h want 1/2/32", tx_start, grant_id, tx_data);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] m_pend;
    logic [7:0]   m_byte [N];
    int           m_ptr;
    logic [N-1:0] prev_req, prev_pend_s, prev_drop_s, req, exp_drop;
    logic [N*DW-1:0] prev_data, data;
    int k;
    int idx;
    do_reset();
    resp_en = 1'b1;
    m_pend = '0; m_ptr = 0;
    for (int i = 0; i < N; i++) m_byte[i] = 8'h00;
    prev_req = '0; prev_data = '0; prev_pend_s = pending; prev_drop_s = drop;
    for (int n = 0; n < 700; n++) begin
      req = '0;
      if (n < 560) for (int i = 0; i < N; i++) if ($urandom_range(0, 7) == 0) req[i] = 1'b1;
      data = 32'($urandom);
      resp_delay = $urandom_range(1, 3); resp_len = $urandom_range(1, 6);
      req_pulse = req; req_data = data;
      tick();
      // a start now means the grant happened on the previous edge
      exp_drop = '0;
      if (tx_start) begin
        k = -1;
        for (int off = 0; off < N; off++) begin
          idx = (m_ptr + off) % N;
          if (k < 0 && m_pend[idx]) k = idx;
        end
        checks++;
        if (k < 0) begin
          errors++; $display("FAIL rnd_grant_empty: cycle %0d start with model pending %b", n, m_pend);
        end else begin
          if (grant_id !== 2'(k) || tx_data !== m_byte[k]) begin
            errors++; $display("FAIL rnd_grant: cycle %0d got id %0d data %h want id %0d data %h", n, grant_id, tx_data, k, m_byte[k]);
          end
          m_pend[k] = 1'b0;
          m_ptr = (k + 1) % N;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (prev_req[i]) begin
          if (m_pend[i]) exp_drop[i] = 1'b1;
          else begin m_pend[i] = 1'b1; m_byte[i] = prev_data[i*DW +: DW]; end
        end
      end
      checks++;
      if (prev_pend_s !== m_pend || prev_drop_s !== exp_drop) begin
        errors++; $display("FAIL rnd_capture: cycle %0d got pend %b drop %b want pend %b drop %b", n, prev_pend_s, prev_drop_s, m_pend, exp_drop);
      end
      prev_req = req; prev_data = data; prev_pend_s = pending; prev_drop_s = drop;
    end
    req_pulse = '0;
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL rnd_drain: got %b want 0000", pending); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    int starts;
    do_reset();
    resp_en = 1'b1; resp_delay = 1; resp_len = 30;
    req_data = 32'h00006100; req_pulse = 4'b0010;
    tick();
    req_pulse = '0;
    wait_start(10, seen);
    for (int i = 0; i < 4; i++) tick();
    req_data = 32'h00720070; req_pulse = 4'b0101;
    tick();
    req_pulse = '0;
    checks++; if (pending !== 4'b0101) begin errors++; $display("FAIL rmid_pending_pre: got %b want 0101", pending); end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; resp_en = 1'b0; tx_busy = 1'b0; busy_left = 0; wait_ctr = 0;
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL rmid_pending: got %b want 0000", pending); end
    checks++; if (tx_start !== 1'b0 || grant_id !== 2'd0 || tx_data !== 8'h00) begin
      errors++; $display("FAIL rmid_outputs: got start %b id %0d data %h want 0/0/00", tx_start, grant_id, tx_data);
    end
    starts = 0;
    for (int i = 0; i < 30; i++) begin tick(); if (tx_start) starts++; end
    checks++; if (starts != 0) begin errors++; $display("FAIL rmid_starts: got %0d want 0", starts); end
  endtask

  initial begin
    rst = 1'b1; req_pulse = '0; req_data = '0; tx_busy = 1'b0;
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_overrun();
    test_timeout();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
